mul_row_sequencer: RTL
======================

# mul_row_sequencer

Schoolbook-multiplication controller sitting in front of the partial-product accumulator (`mul_store`) in the modular-multiplication datapath. On `start_in` it walks operand B word by word (rows) and operand A word by word (columns). It reads both operands from external word-addressable operand memories and forms each 2·register_size-bit word product. It hands the high/low halves, with the row index as the start padding, to the accumulator under its ready/valid handshake, and waits for the accumulator to drain between rows.

## Interface
Parameters:
- `register_size`, 32, word width in bits.
- `num_words`, 64, words per operand (2048/32).
- `desired_size`, 2080, accumulator size in bits; sets the `padding_out` width.

Ports:
- `clk_in`  in  1  single clock.
- `rst_in`  in  1  asynchronous, active-high reset.
- `start_in`  in  1  start one full multiplication; ignored while `busy_out`=1.
- `a_addr_out`  out  $clog2(num_words)  operand A read address.
- `b_addr_out`  out  $clog2(num_words)  operand B read address.
- `a_data_in`  in  register_size  operand A word; valid 1 cycle after the address.
- `b_data_in`  in  register_size  operand B word; valid 1 cycle after the address.
- `high_out`  out  register_size  upper half of the product.
- `low_out`  out  register_size  lower half of the product.
- `padding_out`  out  $clog2(desired_size)+1  current row index, zero-extended.
- `valid_out`  out  1  product word presented to the accumulator.
- `store_ready_in`  in  1  accumulator ready.
- `busy_out`  out  1  high from start acceptance until `done_out`.
- `done_out`  out  1  one-cycle pulse when the last row has drained.

## Operation
- Counters:
  - `row` (0..num_words-1) selects the B word and drives `padding_out`.
  - `col` (0..num_words-1) selects the A word.
- `a_addr_out`=col and `b_addr_out`=row at all times.
- States and transitions:
  - IDLE: start_in → FETCH with row=0, col=0.
  - FETCH: addresses are stable, wait 1 read cycle → MUL.
  - MUL: register `{high,low}` = a_data_in·b_data_in (unsigned, full 2·register_size product, no truncation) → SEND.
  - SEND: valid_out=1 with high/low/padding held stable until the cycle in which store_ready_in=1 (transfer).
    - On transfer with col<num_words-1: col+1, → FETCH.
    - On transfer with col=num_words-1: col=0, → DRAIN.
  - DRAIN: valid_out=0. Wait until store_ready_in has been observed low at least once, then high again.
    - If row<num_words-1: row+1, → FETCH.
    - Otherwise → DONE.
  - DONE: done_out=1 for one cycle, row=0, → IDLE.
- `busy_out` = (state≠IDLE).
- store_ready_in low while in SEND simply stalls; no data is dropped or duplicated.
- start_in during busy is ignored and not queued.
- Reset values (asynchronous, immediate):
  - state=IDLE, row=col=0.
  - valid_out=0, done_out=0, busy_out=0.
  - high_out=low_out=0, padding_out=0.
- Reset mid-operation abandons the row in flight. Accumulator contents are the accumulator's responsibility; it shares `rst_in`.

## Timing
- Per word, with no back-pressure: 3 cycles (FETCH, MUL, SEND).
- Per row: 3·num_words cycles plus the DRAIN time, which is set by the accumulator.
- valid_out rises on the cycle after MUL registers the product.
- The transfer completes on the same edge as store_ready_in=1 sampled with valid_out=1.
- In DRAIN, the ready-low observation must be latched in a flag. A ready that stays high for a cycle after the last transfer must not advance the row.
- done_out is asserted exactly once per accepted start, the cycle after DRAIN exits on the last row.
- All outputs are registered; there are no combinational input-to-output paths except busy_out, which decodes state.

## Structure
- Shared package `mul_pkg`:
  - state enum `mul_seq_state_t` {IDLE, FETCH, MUL, SEND, DRAIN, DONE}.
  - helper constant `WORD_IDX_W` = $clog2(num_words).
- One sub-module is natural: `word_multiplier`, a registered unsigned register_size×register_size→2·register_size multiplier with a one-cycle enable. This keeps the DSP mapping isolated.

## Test plan
Scenarios use register_size=8, num_words=4 unless stated.
- Single-row transfers: A={1,2,3,4}, B={5,0,0,0}, accumulator model always ready within row.
  - Row 0 emits low={5,10,15,20}, high=0, padding=0.
  - Rows 1–3 emit all zeros, padding=1,2,3.
  - done_out pulses once.
- Full-width product: A=B=all 0xFF → every transfer has high=0xFE, low=0x01.
- Back-pressure: hold store_ready_in low for 5 cycles mid-SEND.
  - valid_out and data are held constant.
  - Exactly 16 transfers total.
- Drain handshake: after each row, model ready high for 1 extra cycle, then low 6 cycles, then high.
  - The row advances only after the low→high sequence.
  - padding_out increments once per row.
- Control corner cases:
  - start_in pulsed while busy → ignored; still 16 transfers.
  - Assert rst_in during row 2 → all outputs are 0 immediately and busy_out=0.
  - A new start then restarts at row=0, col=0.

Source files
------------

// File: rtl/mul_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mul_pkg
//  Description : Shared types and helpers for the schoolbook row sequencer.
//  Revision    : 1.0 - initial release
// ============================================================================
package mul_pkg;

    localparam int NUM_WORDS_DEFAULT = 64;

    // Index width that stays legal when only one word is configured.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int WORD_IDX_W = idx_width(NUM_WORDS_DEFAULT);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        FETCH = 3'd1,
        MUL   = 3'd2,
        SEND  = 3'd3,
        DRAIN = 3'd4,
        DONE  = 3'd5
    } mul_seq_state_t;

endpackage
`default_nettype wire

// File: rtl/mul_row_sequencer_if.sv
`default_nettype none
// ============================================================================
//  Module      : mul_row_sequencer_if
//  Description : Operand-memory, accumulator and control bus of the sequencer.
//  Revision    : 1.0 - initial release
// ============================================================================
interface mul_row_sequencer_if #(
    parameter int register_size = 32,
    parameter int num_words     = 64,
    parameter int desired_size  = 2080
) ();
    import mul_pkg::*;

    localparam int IDX_W = idx_width(num_words);
    localparam int PAD_W = $clog2(desired_size) + 1;

    logic                     start_in;
    logic [IDX_W-1:0]         a_addr_out;
    logic [IDX_W-1:0]         b_addr_out;
    logic [register_size-1:0] a_data_in;
    logic [register_size-1:0] b_data_in;
    logic [register_size-1:0] high_out;
    logic [register_size-1:0] low_out;
    logic [PAD_W-1:0]         padding_out;
    logic                     valid_out;
    logic                     store_ready_in;
    logic                     busy_out;
    logic                     done_out;

    modport master (
        input  start_in, a_data_in, b_data_in, store_ready_in,
        output a_addr_out, b_addr_out, high_out, low_out, padding_out,
               valid_out, busy_out, done_out
    );

    modport slave (
        output start_in, a_data_in, b_data_in, store_ready_in,
        input  a_addr_out, b_addr_out, high_out, low_out, padding_out,
               valid_out, busy_out, done_out
    );

endinterface
`default_nettype wire

// File: rtl/word_multiplier.sv
`default_nettype none
// ============================================================================
//  Module      : word_multiplier
//  Description : Registered unsigned word x word multiplier with load enable.
//  Revision    : 1.0 - initial release
// ============================================================================
module word_multiplier #(
    parameter int register_size = 32
) (
    input  wire logic                       clk_in,
    input  wire logic                       rst_in,
    input  wire logic                       en_i,
    input  wire logic [register_size-1:0]   a_i,
    input  wire logic [register_size-1:0]   b_i,
    output logic      [2*register_size-1:0] product_o
);
    logic [2*register_size-1:0] product_q;

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            product_q <= '0;
        end else if (en_i) begin
            product_q <= {{register_size{1'b0}}, a_i} * {{register_size{1'b0}}, b_i};
        end
    end

    assign product_o = product_q;

endmodule
`default_nettype wire

// File: rtl/mul_row_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : mul_row_sequencer
//  Description : Walks B rows x A columns, feeding word products to mul_store.
//  Revision    : 1.0 - initial release
// ============================================================================
module mul_row_sequencer #(
    parameter int register_size = 32,
    parameter int num_words     = 64,
    parameter int desired_size  = 2080
) (
    input  wire logic          clk_in,
    input  wire logic          rst_in,
    mul_row_sequencer_if.master bus
);
    import mul_pkg::*;

    localparam int               IDX_W    = idx_width(num_words);
    localparam int               PAD_W    = $clog2(desired_size) + 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(num_words - 1);

    mul_seq_state_t             state_q;
    logic [IDX_W-1:0]           row_q;
    logic [IDX_W-1:0]           col_q;
    logic                       valid_q;
    logic                       done_q;
    logic                       seen_low_q;
    logic                       mul_en;
    logic [2*register_size-1:0] product;

    assign mul_en = (state_q == MUL);

    word_multiplier #(
        .register_size (register_size)
    ) u_word_multiplier (
        .clk_in    (clk_in),
        .rst_in    (rst_in),
        .en_i      (mul_en),
        .a_i       (bus.a_data_in),
        .b_i       (bus.b_data_in),
        .product_o (product)
    );

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state_q    <= IDLE;
            row_q      <= '0;
            col_q      <= '0;
            valid_q    <= 1'b0;
            done_q     <= 1'b0;
            seen_low_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (bus.start_in) begin
                        row_q   <= '0;
                        col_q   <= '0;
                        state_q <= FETCH;
                    end
                end
                FETCH: state_q <= MUL;
                MUL: begin
                    valid_q <= 1'b1;
                    state_q <= SEND;
                end
                SEND: begin
                    if (bus.store_ready_in) begin
                        valid_q <= 1'b0;
                        if (col_q == LAST_IDX) begin
                            col_q      <= '0;
                            seen_low_q <= 1'b0;
                            state_q    <= DRAIN;
                        end else begin
                            col_q   <= col_q + 1'b1;
                            state_q <= FETCH;
                        end
                    end
                end
                // A ready still high from the last transfer is not a drain;
                // the row only advances after ready has dropped and returned.
                DRAIN: begin
                    if (!bus.store_ready_in) begin
                        seen_low_q <= 1'b1;
                    end else if (seen_low_q) begin
                        seen_low_q <= 1'b0;
                        if (row_q == LAST_IDX) begin
                            done_q  <= 1'b1;
                            state_q <= DONE;
                        end else begin
                            row_q   <= row_q + 1'b1;
                            state_q <= FETCH;
                        end
                    end
                end
                DONE: begin
                    row_q   <= '0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.a_addr_out  = col_q;
    assign bus.b_addr_out  = row_q;
    assign bus.high_out    = product[2*register_size-1:register_size];
    assign bus.low_out     = product[register_size-1:0];
    assign bus.padding_out = PAD_W'(row_q);
    assign bus.valid_out   = valid_q;
    assign bus.done_out    = done_q;
    assign bus.busy_out    = (state_q != IDLE);

endmodule
`default_nettype wire
